// File: rtl/mouse_pkg.sv
// Shared constants and packet type for the PS/2 mouse cursor path.
package mouse_pkg;
  localparam int unsigned H_RES    = 640;
  localparam int unsigned V_RES    = 480;
  localparam int unsigned X_CENTRE = H_RES / 2;
  localparam int unsigned Y_CENTRE = V_RES / 2;

  localparam int unsigned DW    = 9;
  localparam int unsigned NBTN  = 3;
  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_M = 2;

  typedef struct packed {
    logic [DW-1:0]   dx;
    logic [DW-1:0]   dy;
    logic [NBTN-1:0] btn;
  } pkt_t;
endpackage

// File: rtl/mouse_cursor_axis_acc.sv
// One cursor axis: scales a signed delta, accumulates it and clamps to 0..MAX.
module axis_acc
  import mouse_pkg::*;
#(
  parameter int unsigned W      = 10,
  parameter int unsigned MAX    = 639,
  parameter int unsigned INIT   = 320,
  parameter int unsigned SHIFT  = 0,
  parameter bit          INVERT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] delta,
  input  logic          valid,
  input  logic          recenter,
  output logic [W-1:0]  pos
);
  // Two guard bits keep pos +/- delta free of overflow before clamping.
  localparam int unsigned EW = W + 2;
  localparam logic signed [EW-1:0] MAX_S = EW'(MAX);

  logic signed [EW-1:0] d_ext;
  logic signed [EW-1:0] d_sh;
  logic signed [EW-1:0] base;
  logic signed [EW-1:0] sum;
  logic [W-1:0]         clamped;

  always_comb begin
    d_ext = {{(EW-DW){delta[DW-1]}}, delta};
    d_sh  = d_ext >>> SHIFT;
    base  = $signed({2'b00, pos});
    sum   = INVERT ? (base - d_sh) : (base + d_sh);
    if (sum[EW-1])
      clamped = '0;
    else if (sum > MAX_S)
      clamped = W'(MAX);
    else
      clamped = sum[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pos <= W'(INIT);
    else if (recenter)
      pos <= W'(INIT);
    else if (valid)
      pos <= clamped;
  end
endmodule

// File: rtl/mouse_cursor.sv
// Turns decoded PS/2 mouse packets into a clamped screen position,
// button edge ticks and an inactivity flag.
module mouse_cursor
  import mouse_pkg::*;
#(
  parameter int unsigned X_MAX    = H_RES - 1,
  parameter int unsigned Y_MAX    = V_RES - 1,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 10,
  parameter int unsigned X_INIT   = X_CENTRE,
  parameter int unsigned Y_INIT   = Y_CENTRE,
  parameter int unsigned SHIFT    = 0,
  parameter int unsigned IDLE_CYC = 50_000_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m_done_tick,
  input  logic [DW-1:0]   dx,
  input  logic [DW-1:0]   dy,
  input  logic [NBTN-1:0] btn,
  input  logic            recenter,
  output logic [XW-1:0]   pos_x,
  output logic [YW-1:0]   pos_y,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic            upd_tick,
  output logic            idle
);
  localparam int unsigned CW = $clog2(IDLE_CYC + 1);

  pkt_t          pkt_s1;
  logic          valid_s1;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] idle_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_s1   <= '0;
      valid_s1 <= 1'b0;
    end else begin
      valid_s1 <= m_done_tick;
      if (m_done_tick)
        pkt_s1 <= '{dx: dx, dy: dy, btn: btn};
    end
  end

  axis_acc #(
    .W(XW), .MAX(X_MAX), .INIT(X_INIT), .SHIFT(SHIFT), .INVERT(1'b0)
  ) u_x (
    .clk(clk), .rst_n(rst_n), .delta(pkt_s1.dx), .valid(valid_s1),
    .recenter(recenter), .pos(pos_x)
  );

  // Screen Y grows downward, so an upward mouse delta is subtracted.
  axis_acc #(
    .W(YW), .MAX(Y_MAX), .INIT(Y_INIT), .SHIFT(SHIFT), .INVERT(1'b1)
  ) u_y (
    .clk(clk), .rst_n(rst_n), .delta(pkt_s1.dy), .valid(valid_s1),
    .recenter(recenter), .pos(pos_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      upd_tick    <= 1'b0;
    end else begin
      upd_tick <= valid_s1;
      if (valid_s1) begin
        btn_press   <= pkt_s1.btn & ~btn_level;
        btn_release <= ~pkt_s1.btn & btn_level;
        btn_level   <= pkt_s1.btn;
      end else begin
        btn_press   <= '0;
        btn_release <= '0;
      end
    end
  end

  always_comb begin
    if (m_done_tick)
      idle_cnt_next = '0;
    else if (idle_cnt == CW'(IDLE_CYC))
      idle_cnt_next = idle_cnt;
    else
      idle_cnt_next = idle_cnt + 1'b1;
  end

  // idle is registered from the next count so it rises in the same cycle
  // the counter reaches IDLE_CYC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      idle     <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_next;
      idle     <= (idle_cnt_next == CW'(IDLE_CYC));
    end
  end
endmodule

// File: tb/tb_mouse_cursor.sv
// Bench for mouse_cursor: directed vector table, hand-written corner cases,
// and random traffic checked every cycle against a packet-level model.
module tb_mouse_cursor;
  localparam int IDLE_N = 100;
  localparam int XMAX   = 639;
  localparam int YMAX   = 479;
  localparam int XI     = 320;
  localparam int YI     = 240;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m_done_tick;
  logic [8:0] dx, dy;
  logic [2:0] btn;
  logic       recenter;

  logic [9:0] pos_x0, pos_y0, pos_x1, pos_y1;
  logic [2:0] lvl0, prs0, rel0, lvl1, prs1, rel1;
  logic       upd0, idle0, upd1, idle1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mouse_cursor #(.IDLE_CYC(IDLE_N)) u_dut (
    .clk(clk), .rst_n(rst_n), .m_done_tick(m_done_tick), .dx(dx), .dy(dy),
    .btn(btn), .recenter(recenter), .pos_x(pos_x0), .pos_y(pos_y0),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0),
    .upd_tick(upd0), .idle(idle0)
  );

  mouse_cursor #(.SHIFT(2), .IDLE_CYC(IDLE_N)) u_dut_sh (
    .clk(clk), .rst_n(rst_n), .m_done_tick(m_done_tick), .dx(dx), .dy(dy),
    .btn(btn), .recenter(recenter), .pos_x(pos_x1), .pos_y(pos_y1),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1),
    .upd_tick(upd1), .idle(idle1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  int mx[2], my[2];
  int mlvl, mprs, mrel, mupd, midle, msince;
  bit pend;
  int pdx, pdy, pbtn;
  int sh[2] = '{0, 2};

  function automatic int sx9(input logic [8:0] v);
    return v[8] ? int'(v) - 512 : int'(v);
  endfunction

  // Division by 2^s rounding toward minus infinity.
  function automatic int fdiv(input int d, input int s);
    int q;
    q = 1 << s;
    if (d >= 0) return d / q;
    return -((-d + q - 1) / q);
  endfunction

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mx[i] = XI;
      my[i] = YI;
    end
    mlvl = 0; mprs = 0; mrel = 0; mupd = 0; midle = 0; msince = 0;
    pend = 1'b0; pdx = 0; pdy = 0; pbtn = 0;
  endtask

  task automatic model_edge();
    mprs = 0; mrel = 0; mupd = 0;
    if (pend) begin
      for (int i = 0; i < 2; i++) begin
        mx[i] = clamp(mx[i] + fdiv(pdx, sh[i]), XMAX);
        my[i] = clamp(my[i] - fdiv(pdy, sh[i]), YMAX);
      end
      mprs = pbtn & ~mlvl & 7;
      mrel = ~pbtn & mlvl & 7;
      mlvl = pbtn;
      mupd = 1;
    end
    if (recenter) begin
      for (int i = 0; i < 2; i++) begin
        mx[i] = XI;
        my[i] = YI;
      end
    end
    pend = m_done_tick;
    if (m_done_tick) begin
      pdx = sx9(dx); pdy = sx9(dy); pbtn = int'(btn);
      msince = 0;
    end else if (msince < IDLE_N) begin
      msince++;
    end
    midle = (msince == IDLE_N) ? 1 : 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  task automatic cmp_dut(input int i, input logic [9:0] px, input logic [9:0] py,
                         input logic [2:0] l, input logic [2:0] p, input logic [2:0] r,
                         input logic u, input logic id);
    check($sformatf("dut%0d.pos_x", i), px, mx[i]);
    check($sformatf("dut%0d.pos_y", i), py, my[i]);
    check($sformatf("dut%0d.btn_level", i), l, mlvl);
    check($sformatf("dut%0d.btn_press", i), p, mprs);
    check($sformatf("dut%0d.btn_release", i), r, mrel);
    check($sformatf("dut%0d.upd_tick", i), u, mupd);
    check($sformatf("dut%0d.idle", i), id, midle);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      cmp_dut(0, pos_x0, pos_y0, lvl0, prs0, rel0, upd0, idle0);
      cmp_dut(1, pos_x1, pos_y1, lvl1, prs1, rel1, upd1, idle1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic t, input logic [8:0] x, input logic [8:0] y,
                     input logic [2:0] b, input logic r);
    @(negedge clk);
    #1;
    m_done_tick = t; dx = x; dy = y; btn = b; recenter = r;
  endtask

  task automatic quiet(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 9'd0, 9'd0, 3'b000, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    m_done_tick = 1'b0; recenter = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [8:0] vdx;
    logic [8:0] vdy;
    logic [2:0] vbtn;
    int         ex;
    int         ey;
    logic [2:0] eprs;
    logic [2:0] erel;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; m_done_tick = 1'b0; dx = '0; dy = '0; btn = '0; recenter = 1'b0;

    tbl[0] = '{9'd5,   9'd3,   3'b000, 325, 237, 3'b000, 3'b000};
    tbl[1] = '{9'd255, 9'd0,   3'b001, 580, 237, 3'b001, 3'b000};
    tbl[2] = '{9'd55,  9'd235, 3'b011, 635, 2,   3'b010, 3'b000};
    tbl[3] = '{9'd20,  9'd10,  3'b010, 639, 0,   3'b000, 3'b001};
    tbl[4] = '{9'h100, 9'h100, 3'b000, 383, 256, 3'b000, 3'b010};
    tbl[5] = '{9'h181, 9'd0,   3'b100, 256, 256, 3'b100, 3'b000};
    tbl[6] = '{9'h100, 9'h1FF, 3'b100, 0,   257, 3'b000, 3'b000};
    tbl[7] = '{9'h1FF, 9'h101, 3'b000, 0,   479, 3'b000, 3'b100};
    tbl[8] = '{9'd0,   9'd0,   3'b000, 0,   479, 3'b000, 3'b000};

    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    check("reset.pos_x", pos_x0, XI);
    check("reset.pos_y", pos_y0, YI);
    check("reset.btn_level", lvl0, 0);
    check("reset.upd_tick", upd0, 0);
    check("reset.idle", idle0, 0);

    // Directed vector table; results appear two edges after the strobe.
    foreach (tbl[i]) begin
      cyc(1'b1, tbl[i].vdx, tbl[i].vdy, tbl[i].vbtn, 1'b0);
      quiet(2);
      check($sformatf("tbl%0d.pos_x", i), pos_x0, tbl[i].ex);
      check($sformatf("tbl%0d.pos_y", i), pos_y0, tbl[i].ey);
      check($sformatf("tbl%0d.press", i), prs0, tbl[i].eprs);
      check($sformatf("tbl%0d.release", i), rel0, tbl[i].erel);
      check($sformatf("tbl%0d.level", i), lvl0, tbl[i].vbtn);
      check($sformatf("tbl%0d.upd", i), upd0, 1);
      quiet(1);
      check($sformatf("tbl%0d.upd_gone", i), upd0, 0);
      check($sformatf("tbl%0d.press_gone", i), prs0, 0);
    end

    // Sensitivity divider: -1 must stay -1 after the shift.
    do_reset();
    cyc(1'b1, 9'd7, 9'd0, 3'b000, 1'b0);
    quiet(2);
    check("shift.plus7", pos_x1, 321);
    cyc(1'b1, 9'h1FF, 9'd0, 3'b000, 1'b0);
    quiet(2);
    check("shift.minus1", pos_x1, 320);

    // Recenter coinciding with the stage-2 update.
    do_reset();
    cyc(1'b1, 9'd50, 9'd0, 3'b001, 1'b0);
    cyc(1'b0, 9'd0, 9'd0, 3'b000, 1'b1);
    quiet(1);
    check("recenter.pos_x", pos_x0, XI);
    check("recenter.pos_y", pos_y0, YI);
    check("recenter.upd", upd0, 1);
    check("recenter.press", prs0, 3'b001);
    check("recenter.level", lvl0, 3'b001);

    // Idle timing, bounded wait.
    do_reset();
    cyc(1'b1, 9'd1, 9'd1, 3'b000, 1'b0);
    n = 0;
    while (n < 400) begin
      quiet(1);
      n++;
      if (idle0) break;
    end
    check("idle.rise_cycles", n, IDLE_N + 1);
    cyc(1'b1, 9'd0, 9'd0, 3'b000, 1'b0);
    quiet(1);
    check("idle.fall", idle0, 0);

    // Reset between capture and update discards the packet.
    do_reset();
    cyc(1'b1, 9'd30, 9'd0, 3'b001, 1'b0);
    @(negedge clk);
    #1;
    m_done_tick = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      quiet(1);
      check("midreset.upd", upd0, 0);
    end
    check("midreset.pos_x", pos_x0, XI);
    check("midreset.level", lvl0, 0);

    // Random traffic, including back-to-back strobes and recenters.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) quiet(105);
      cyc(1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom), 3'($urandom),
          ($urandom_range(0, 15) == 0));
    end
    quiet(4);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
